// File: rtl/icsp_loader.sv
// icsp_loader: ICSP slave that shifts PGC/PGD commands and data in/out and
// writes 14-bit words into program memory while holding the CPU core off.
module icsp_loader #(
   parameter int ADDR_W      = 12,
   parameter int PROG_CYCLES = 8
) (
   input  logic              master_clk,
   input  logic              reset_n,
   input  logic              prog_mode,
   input  logic              pgc,
   input  logic              pgd_in,
   output logic              pgd_out,
   output logic              pgd_oe,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [13:0]       mem_wdata,
   output logic              mem_we,
   input  logic [13:0]       mem_rdata,
   output logic              cpu_hold,
   output logic              busy
);
   localparam int WW = $clog2(PROG_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, CMD, DIN, DOUT, WRITE, WAIT} state_t;

   state_t          state;
   logic [1:0]      pgc_s, pgd_s;
   logic            pgc_q, rise, fall, bit_in, cap;
   logic [3:0]      cnt;
   logic [4:0]      cmd_sh;
   logic [5:0]      cmd;
   logic [13:0]     latch;
   logic [15:0]     frame;
   logic [WW-1:0]   wcnt;

   assign rise   = pgc_s[1] & ~pgc_q;
   assign fall   = ~pgc_s[1] & pgc_q;
   assign bit_in = pgd_s[1];
   // full command word as it stands once the 6th bit is on the line
   assign cmd    = {bit_in, cmd_sh};

   always_ff @(posedge master_clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         pgc_s     <= '0;
         pgd_s     <= '0;
         pgc_q     <= 1'b0;
         cnt       <= '0;
         cmd_sh    <= '0;
         latch     <= '0;
         frame     <= '0;
         cap       <= 1'b0;
         wcnt      <= '0;
         pgd_out   <= 1'b0;
         pgd_oe    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         cpu_hold  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         pgc_s    <= {pgc_s[0], pgc};
         pgd_s    <= {pgd_s[0], pgd_in};
         pgc_q    <= pgc_s[1];
         cpu_hold <= prog_mode;
         mem_we   <= 1'b0;
         if (!prog_mode) begin
            state  <= IDLE;
            pgd_oe <= 1'b0;
            busy   <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state    <= CMD;
                  mem_addr <= '0;
                  latch    <= '0;
                  cnt      <= '0;
               end
               CMD: if (fall) begin
                  cmd_sh <= {bit_in, cmd_sh[4:1]};
                  cnt    <= cnt + 4'd1;
                  if (cnt == 4'd5) begin
                     cnt    <= '0;
                     state  <= cmd == 6'h02 ? DIN : cmd == 6'h04 ? DOUT : cmd == 6'h08 ? WRITE : CMD;
                     cap    <= cmd == 6'h04;
                     mem_we <= cmd == 6'h08;
                     if (cmd == 6'h06) mem_addr <= mem_addr + 1'b1;
                  end
               end
               DIN: if (fall) begin
                  cnt <= cnt + 4'd1;
                  if (cnt == 4'd15) begin
                     mem_wdata <= latch;
                     state     <= CMD;
                  end else if (cnt != 4'd0) latch <= {bit_in, latch[13:1]};
               end
               DOUT: begin
                  // frame is start(0), data LSB first, stop(0)
                  if (cap) begin
                     frame  <= {1'b0, mem_rdata, 1'b0};
                     pgd_oe <= 1'b1;
                     cap    <= 1'b0;
                  end else if (rise) begin
                     pgd_out <= frame[0];
                     frame   <= {1'b0, frame[15:1]};
                  end
                  if (fall) begin
                     cnt <= cnt + 4'd1;
                     if (cnt == 4'd15) begin
                        pgd_oe <= 1'b0;
                        state  <= CMD;
                     end
                  end
               end
               WRITE: begin
                  busy  <= 1'b1;
                  wcnt  <= WW'(PROG_CYCLES - 1);
                  state <= WAIT;
               end
               WAIT: begin
                  if (wcnt == '0) begin
                     busy  <= 1'b0;
                     cnt   <= '0;
                     state <= CMD;
                  end else wcnt <= wcnt - 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: doc/icsp_loader.md
# icsp_loader

In-circuit serial programming (ICSP) slave for the PIC16F84 core: it receives the host's serial PGC/PGD command stream and writes 14-bit instruction words into program memory at a loader-owned address. It also reads words back out serially for verification. It sits beside `flash_program_memory` as the write-side counterpart of the instruction fetch path. While programming mode is active it holds the CPU core off (pc in reset, fetch disabled).

## Interface
- ADDR_W, 12, program memory address width (matches pc width)
- PROG_CYCLES, 8, master_clk cycles `busy` stays high after a write pulse
- master_clk  input  1  system clock; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- prog_mode  input  1  programming-mode enable (MCLR/VPP qualified), level
- pgc  input  1  host serial clock, asynchronous to master_clk
- pgd_in  input  1  host serial data, asynchronous to master_clk
- pgd_out  output  1  serial read data
- pgd_oe  output  1  high while the loader drives PGD
- mem_addr  output  ADDR_W  program memory address
- mem_wdata  output  14  word to write
- mem_we  output  1  single-cycle write strobe
- mem_rdata  input  14  program memory read data, valid one master_clk cycle after mem_addr changes
- cpu_hold  output  1  high while prog_mode is active; core held in reset
- busy  output  1  write in progress

## Operation
- Synchronization:
  - pgc and pgd_in each pass through a 2-flop synchronizer.
  - The synchronized pgc feeds an edge detector that produces single-cycle rise and fall pulses.
- Bit transfers:
  - Host-to-loader bits are sampled on the pgc fall pulse, LSB first.
  - Loader-to-host bits change on the pgc rise pulse.
- States:
  - IDLE: prog_mode low; everything quiescent.
  - CMD: shift in 6 command bits.
  - DIN: 16-bit data frame in.
  - DOUT: 16-bit data frame out.
  - WRITE: one-cycle write.
  - WAIT: busy countdown.
- Entry into programming mode: a prog_mode rising edge (IDLE→CMD) clears mem_addr and the data latch to 0 and asserts cpu_hold.
- Commands are decoded after the 6th bit:
  - 0x02 Load Data → DIN.
  - 0x04 Read Data → DOUT.
  - 0x06 Increment Address: mem_addr+1, wrapping from 2^ADDR_W−1 to 0; stay in CMD.
  - 0x08 Begin Programming → WRITE.
  - Any other value is a no-op; stay in CMD.
- DIN frame:
  - Bit 0 (start) and bit 15 (stop) are discarded.
  - Bits 1..14 go into the data latch as data[0..13].
  - The latch is committed to mem_wdata only after bit 15; a partial frame leaves mem_wdata unchanged.
- DOUT frame:
  - mem_rdata is captured into the output shift register on the cycle after decode.
  - pgd_oe rises on the same cycle as the capture.
  - Output sequence on successive rise pulses: 0 (start), data[0..13], 0 (stop).
  - pgd_oe drops on the fall pulse that ends bit 15.
- WRITE: mem_we is high for exactly one cycle with the current mem_addr and mem_wdata, then the block moves to WAIT.
- WAIT:
  - busy stays high for PROG_CYCLES cycles.
  - pgc edges during WAIT are ignored; any bits clocked in are lost.
  - The block then returns to CMD.
- prog_mode falling in any state aborts immediately:
  - Go to IDLE; clear pgd_oe, mem_we, busy and cpu_hold.
  - mem_addr and mem_wdata are retained.

## Timing
- Reset values:
  - pgd_out=0, pgd_oe=0, mem_we=0, busy=0, cpu_hold=0.
  - mem_addr=0, mem_wdata=0; state=IDLE.
- pgc high and low phases must each be ≥4 master_clk cycles; pgd_in must be stable from 3 cycles before to 1 cycle after each pgc fall.
- Input latency: 3 master_clk cycles from a pgc edge to its edge pulse.
- Decode acts on the cycle after the 6th fall pulse:
  - mem_we asserts on that cycle for 0x08.
  - mem_addr updates on that cycle for 0x06.
- busy rises on the cycle after mem_we and stays high for PROG_CYCLES cycles.
- cpu_hold follows prog_mode with 1 cycle of latency.
- If reset_n is asserted mid-frame, the state and all outputs return to their reset values asynchronously.

## Test plan
- prog_mode=1; send cmd 0x02 with data 0x3FFF, then cmd 0x08 → one mem_we pulse with mem_addr=0, mem_wdata=0x3FFF; busy high for 8 cycles.
- Send 0x06 three times, then 0x02 with 0x2A5C and 0x08 → write at mem_addr=3, data 0x2A5C.
- mem_rdata=0x1234, send cmd 0x04 → pgd_out gives 0, bits of 0x1234 LSB first, 0; pgd_oe high for the whole frame only.
- Force mem_addr=0xFFF (4095 increments), send 0x06 → mem_addr=0x000.
- Drop prog_mode after 7 bits of a Load Data frame → IDLE, cpu_hold=0, no mem_we, mem_wdata unchanged; raising prog_mode again gives mem_addr=0.
- Send unknown cmd 0x3F, then 0x06 → first command is a no-op, mem_addr=1. Assert reset_n low mid-DOUT → pgd_oe=0 immediately.
